lsq_ptr_gen_mp: RTL and testbench

Multi-port pointer and occupancy tracker for the sparse load/store queue buffers in the issue stage. Up to WR_PORTS entries are allocated in order at the tail each cycle, and up to RD_PORTS entries are released out of order. The bottom (head) pointer skips every contiguous released entry in one cycle. The block owns the per-entry valid bitmap, reports full/empty/count with wrap-bit pointers, and supports tail rollback (flush) on mispredict.

---
 rtl/lsq_ptr_gen_mp_pkg.sv | 29 ++
 rtl/lsq_ptr_gen_mp_if.sv | 35 +++
 rtl/lsq_ptr_gen_mp_head_scan.sv | 42 ++++
 rtl/lsq_ptr_gen_mp.sv | 110 +++++++++++
 tb/tb_lsq_ptr_gen_mp.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lsq_ptr_gen_mp_pkg.sv
// Shared LSQ sizing defaults and wrap-pointer arithmetic helpers.
// Helpers work on 32-bit containers; callers cast the result back to PTR_W+1 bits.
package lsq_pkg;

  localparam int LSQ_DEPTH    = 8;
  localparam int LSQ_WR_PORTS = 2;
  localparam int LSQ_RD_PORTS = 2;

  function automatic logic [31:0] ptr_mask(input int unsigned pw);
    return (32'd1 << (pw + 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] ptr_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned pw);
    return (a + b) & ptr_mask(pw);
  endfunction

  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned pw);
    return (a - b) & ptr_mask(pw);
  endfunction

  // Half-open membership test p in [lo, hi) on the lapped pointer circle.
  function automatic logic ptr_in_range(input logic [31:0] p, input logic [31:0] lo,
                                        input logic [31:0] hi, input int unsigned pw);
    return ptr_diff(p, lo, pw) < ptr_diff(hi, lo, pw);
  endfunction

endpackage

// File: rtl/lsq_ptr_gen_mp_if.sv
// Allocation / release / flush handshake and status bundle for the LSQ pointer tracker.
interface lsq_ptr_gen_mp_if
  import lsq_pkg::*;
#(
  parameter int DEPTH    = LSQ_DEPTH,
  parameter int WR_PORTS = LSQ_WR_PORTS,
  parameter int RD_PORTS = LSQ_RD_PORTS
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WR_PORTS-1:0]            alloc_req;
  logic [WR_PORTS-1:0][PTR_W-1:0] alloc_ptr;
  logic                           alloc_ready;
  logic [RD_PORTS-1:0]            rel_valid;
  logic [RD_PORTS-1:0][PTR_W-1:0] rel_ptr;
  logic                           flush_valid;
  logic [PTR_W:0]                 flush_ptr;
  logic [DEPTH-1:0]               entry_valid;
  logic [PTR_W:0]                 bottom_ptr;
  logic [PTR_W:0]                 tail_ptr;
  logic [PTR_W:0]                 count;
  logic                           full;
  logic                           empty;

  modport master (
    output alloc_req, rel_valid, rel_ptr, flush_valid, flush_ptr,
    input  alloc_ptr, alloc_ready, entry_valid, bottom_ptr, tail_ptr, count, full, empty
  );

  modport slave (
    input  alloc_req, rel_valid, rel_ptr, flush_valid, flush_ptr,
    output alloc_ptr, alloc_ready, entry_valid, bottom_ptr, tail_ptr, count, full, empty
  );

endinterface

// File: rtl/lsq_ptr_gen_mp_head_scan.sv
// Finds the oldest still-valid entry in [head, tail) in a single cycle.
// Rotating by head turns the circular search into a plain lowest-bit find-first-set.
module lsq_head_scan
  import lsq_pkg::*;
#(
  parameter  int DEPTH = LSQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [PTR_W:0]   head,
  input  logic [PTR_W:0]   tail,
  output logic [PTR_W:0]   head_nxt
);

  logic [PTR_W:0]   span;
  logic [DEPTH-1:0] rot;
  logic [DEPTH-1:0] live;
  logic [PTR_W-1:0] first;
  logic             found;

  always_comb begin
    span  = tail - head;
    rot   = '0;
    live  = '0;
    first = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rot[i]  = valid[PTR_W'(head[PTR_W-1:0] + PTR_W'(i))];
      live[i] = rot[i] && ((PTR_W+1)'(i) < span);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (live[i]) begin
        first = PTR_W'(i);
        found = 1'b1;
      end
    end
    // Nothing live means everything up to the tail has drained.
    if (found) head_nxt = (PTR_W+1)'(ptr_add(32'(head), 32'(first), PTR_W));
    else       head_nxt = tail;
  end

endmodule

// File: rtl/lsq_ptr_gen_mp.sv
// Multi-port LSQ pointer/occupancy tracker: in-order tail allocation, out-of-order
// release with one-cycle head skip over freed entries, and tail rollback on flush.
module lsq_ptr_gen_mp
  import lsq_pkg::*;
#(
  parameter int DEPTH    = LSQ_DEPTH,
  parameter int WR_PORTS = LSQ_WR_PORTS,
  parameter int RD_PORTS = LSQ_RD_PORTS
) (
  input logic             clk,
  input logic             rst,
  lsq_ptr_gen_mp_if.slave bus
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] WR_P    = (PTR_W+1)'(WR_PORTS);

  logic [DEPTH-1:0]    valid_q, valid_rel, valid_nxt, flush_mask, alloc_mask;
  logic [PTR_W:0]      head_q, tail_q, tail_mid, tail_nxt, head_nxt;
  logic [PTR_W:0]      count, n_alloc;
  logic                ready;
  logic                flush_legal;
  logic [RD_PORTS-1:0] rel_legal;

  assign count           = tail_q - head_q;
  assign ready           = (DEPTH_P - count) >= WR_P;
  assign bus.alloc_ready = ready;
  assign bus.entry_valid = valid_q;
  assign bus.bottom_ptr  = head_q;
  assign bus.tail_ptr    = tail_q;
  assign bus.count       = count;
  assign bus.full        = (count == DEPTH_P);
  assign bus.empty       = (count == '0);

  // Requesting ports are packed onto consecutive slots in port order.
  always_comb begin
    bus.alloc_ptr = '0;
    n_alloc       = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      bus.alloc_ptr[i] = tail_q[PTR_W-1:0] + n_alloc[PTR_W-1:0];
      if (bus.alloc_req[i]) n_alloc = n_alloc + 1'b1;
    end
  end

  always_comb begin
    valid_rel = valid_q;
    for (int j = 0; j < RD_PORTS; j++) begin
      if (bus.rel_valid[j]) valid_rel[bus.rel_ptr[j]] = 1'b0;
    end
    flush_mask = '0;
    tail_mid   = tail_q;
    if (bus.flush_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ({1'b0, PTR_W'(i) - bus.flush_ptr[PTR_W-1:0]} < (tail_q - bus.flush_ptr))
          flush_mask[i] = 1'b1;
      end
      tail_mid = bus.flush_ptr;
    end
    valid_rel = valid_rel & ~flush_mask;

    // New slots sit at or beyond the old tail, so the head scan never sees them.
    alloc_mask = '0;
    tail_nxt   = tail_mid;
    if (!bus.flush_valid && ready) begin
      for (int k = 0; k < WR_PORTS; k++) begin
        if ((PTR_W+1)'(k) < n_alloc)
          alloc_mask[PTR_W'(tail_q[PTR_W-1:0] + PTR_W'(k))] = 1'b1;
      end
      tail_nxt = (PTR_W+1)'(ptr_add(32'(tail_q), 32'(n_alloc), PTR_W));
    end
    valid_nxt = valid_rel | alloc_mask;
  end

  lsq_head_scan #(.DEPTH(DEPTH)) u_head_scan (
    .valid    (valid_rel),
    .head     (head_q),
    .tail     (tail_mid),
    .head_nxt (head_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_nxt;
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
    end
  end

  // A released index is rebuilt into a wrap-pointer relative to the head's lap.
  always_comb begin
    flush_legal = ptr_in_range(32'(bus.flush_ptr), 32'(head_q),
                               ptr_add(32'(tail_q), 32'd1, PTR_W), PTR_W);
    rel_legal = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      rel_legal[j] = !bus.rel_valid[j] ||
        ptr_in_range(32'({head_q[PTR_W] ^ (bus.rel_ptr[j] < head_q[PTR_W-1:0]), bus.rel_ptr[j]}),
                     32'(head_q), 32'(tail_q), PTR_W);
    end
  end

  a_flush_range: assert property (@(posedge clk) disable iff (rst) bus.flush_valid |-> flush_legal);
  a_rel_range:   assert property (@(posedge clk) disable iff (rst) &rel_legal);
  a_alloc_ready: assert property (@(posedge clk) disable iff (rst) |bus.alloc_req |-> ready);

endmodule

// File: tb/tb_lsq_ptr_gen_mp.sv
// Directed plus randomized check of lsq_ptr_gen_mp against an absolute-counter queue model.
module tb_lsq_ptr_gen_mp;
  import lsq_pkg::*;

  localparam int DEPTH = LSQ_DEPTH;
  localparam int WR    = LSQ_WR_PORTS;
  localparam int RD    = LSQ_RD_PORTS;
  localparam int PW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // Model: unbounded head/tail counters and a plain per-slot valid array.
  int m_head;
  int m_tail;
  bit m_valid [DEPTH];

  lsq_ptr_gen_mp_if #(.DEPTH(DEPTH), .WR_PORTS(WR), .RD_PORTS(RD)) bus ();

  lsq_ptr_gen_mp #(.DEPTH(DEPTH), .WR_PORTS(WR), .RD_PORTS(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit m_ready();
    return (DEPTH - (m_tail - m_head)) >= WR;
  endfunction

  task automatic model_step(input logic [WR-1:0] req, input logic [RD-1:0] rv,
                            input logic [RD-1:0][PW-1:0] rp, input logic fv,
                            input logic [PW:0] fp, input logic r);
    bit ready;
    int back;
    int fabs;
    if (r) begin
      m_head = 0;
      m_tail = 0;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      return;
    end
    ready = m_ready();
    for (int j = 0; j < RD; j++) if (rv[j]) m_valid[rp[j]] = 1'b0;
    if (fv) begin
      back = ((m_tail % (2 * DEPTH)) - int'(fp) + 2 * DEPTH) % (2 * DEPTH);
      fabs = m_tail - back;
      for (int a = fabs; a < m_tail; a++) m_valid[a % DEPTH] = 1'b0;
      m_tail = fabs;
    end
    while (m_head < m_tail && !m_valid[m_head % DEPTH]) m_head++;
    if (!fv && ready) begin
      for (int i = 0; i < WR; i++) begin
        if (req[i]) begin
          m_valid[m_tail % DEPTH] = 1'b1;
          m_tail++;
        end
      end
    end
  endtask

  task automatic check_output();
    logic [DEPTH-1:0] ev;
    for (int i = 0; i < DEPTH; i++) ev[i] = m_valid[i];
    check("entry_valid", 32'(bus.entry_valid), 32'(ev));
    check("bottom_ptr",  32'(bus.bottom_ptr),  m_head % (2 * DEPTH));
    check("tail_ptr",    32'(bus.tail_ptr),    m_tail % (2 * DEPTH));
    check("count",       32'(bus.count),       m_tail - m_head);
    check("full",        32'(bus.full),        32'((m_tail - m_head) == DEPTH));
    check("empty",       32'(bus.empty),       32'(m_tail == m_head));
    check("alloc_ready", 32'(bus.alloc_ready), 32'(m_ready()));
  endtask

  task automatic apply_stimulus(input logic [WR-1:0] req, input logic [RD-1:0] rv,
                                input logic [RD-1:0][PW-1:0] rp, input logic fv,
                                input logic [PW:0] fp, input logic r);
    int ofs;
    @(negedge clk);
    rst             = r;
    bus.alloc_req   = req;
    bus.rel_valid   = rv;
    bus.rel_ptr     = rp;
    bus.flush_valid = fv;
    bus.flush_ptr   = fp;
    #1;
    ofs = 0;
    for (int i = 0; i < WR; i++) begin
      if (req[i]) begin
        check("alloc_ptr", 32'(bus.alloc_ptr[i]), (m_tail + ofs) % DEPTH);
        ofs++;
      end
    end
    model_step(req, rv, rp, fv, fp, r);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    logic [WR-1:0]         req;
    logic [RD-1:0]         rv;
    logic [RD-1:0][PW-1:0] rp;
    logic                  fv;
    logic [PW:0]           fp;
    logic                  r;
    int                    cnt;

    rst             = 1'b1;
    bus.alloc_req   = '0;
    bus.rel_valid   = '0;
    bus.rel_ptr     = '0;
    bus.flush_valid = 1'b0;
    bus.flush_ptr   = '0;
    m_head = 0;
    m_tail = 0;

    apply_stimulus('0, '0, '0, 1'b0, '0, 1'b1);

    // Fill from empty on both ports.
    for (int c = 0; c < 4; c++) apply_stimulus(2'b11, '0, '0, 1'b0, '0, 1'b0);
    check("fill_full",  32'(bus.full),        32'd1);
    check("fill_ready", 32'(bus.alloc_ready), 32'd0);
    check("fill_count", 32'(bus.count),       32'd8);

    // Out-of-order release: head waits for entry 0, then skips 1 and 2.
    apply_stimulus('0, 2'b11, {PW'(2), PW'(1)}, 1'b0, '0, 1'b0);
    check("hold_bottom", 32'(bus.bottom_ptr), 32'd0);
    apply_stimulus('0, 2'b01, {PW'(0), PW'(0)}, 1'b0, '0, 1'b0);
    check("skip_bottom", 32'(bus.bottom_ptr), 32'd3);
    check("skip_count",  32'(bus.count),      32'd5);

    // Wrap: drain to head = tail = 6, then allocate across the end.
    apply_stimulus('0, '0, '0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 3; c++) apply_stimulus(2'b11, '0, '0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 3; c++)
      apply_stimulus('0, 2'b11, {PW'(2 * c + 1), PW'(2 * c)}, 1'b0, '0, 1'b0);
    apply_stimulus(2'b11, '0, '0, 1'b0, '0, 1'b0);
    apply_stimulus(2'b11, '0, '0, 1'b0, '0, 1'b0);
    check("wrap_tail", 32'(bus.tail_ptr), 32'b1010);

    // Flush with same-cycle release and suppressed allocation.
    apply_stimulus('0, '0, '0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 3; c++) apply_stimulus(2'b11, '0, '0, 1'b0, '0, 1'b0);
    apply_stimulus(2'b01, '0, '0, 1'b0, '0, 1'b0);
    apply_stimulus('0, 2'b11, {PW'(1), PW'(0)}, 1'b0, '0, 1'b0);
    apply_stimulus(2'b11, 2'b01, {PW'(0), PW'(2)}, 1'b1, (PW+1)'(4), 1'b0);
    check("flush_tail",   32'(bus.tail_ptr),          32'd4);
    check("flush_clear",  32'(bus.entry_valid[6:4]),  32'd0);
    check("flush_bottom", 32'(bus.bottom_ptr),        32'd3);

    // Duplicate release, then release of an already-free entry.
    apply_stimulus(2'b11, '0, '0, 1'b0, '0, 1'b0);
    apply_stimulus(2'b11, '0, '0, 1'b0, '0, 1'b0);
    apply_stimulus('0, 2'b11, {PW'(5), PW'(5)}, 1'b0, '0, 1'b0);
    check("dup_count", 32'(bus.count), 32'd5);
    apply_stimulus('0, 2'b01, {PW'(0), PW'(5)}, 1'b0, '0, 1'b0);
    check("noop_count", 32'(bus.count), 32'd5);

    // Reset wins over simultaneous alloc, release and flush.
    apply_stimulus(2'b11, 2'b01, {PW'(0), PW'(3)}, 1'b1, (PW+1)'(6), 1'b1);
    check("rst_empty", 32'(bus.empty),    32'd1);
    check("rst_tail",  32'(bus.tail_ptr), 32'd0);

    // Randomized legal traffic with occasional flush and reset.
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 49) == 0);
      cnt = m_tail - m_head;
      req = m_ready() ? WR'($urandom) : '0;
      rv  = '0;
      rp  = '0;
      for (int j = 0; j < RD; j++) begin
        if (cnt > 0 && $urandom_range(0, 1) == 1) begin
          rv[j] = 1'b1;
          rp[j] = PW'((m_head + int'($urandom_range(0, cnt - 1))) % DEPTH);
        end
      end
      fv = ($urandom_range(0, 7) == 0);
      fp = fv ? (PW+1)'((m_head + int'($urandom_range(0, cnt))) % (2 * DEPTH)) : '0;
      apply_stimulus(req, rv, rp, fv, fp, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
